// File: rtl/src_pkg.sv
// Shared types for the operand source sequencer and the operand mux.
package src_pkg;

    localparam int IO_TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        SRC_B   = 3'b000,
        SRC_IMM = 3'b001,
        SRC_MEM = 3'b010,
        SRC_IO  = 3'b011,
        SRC_PC  = 3'b100,
        SRC_SP  = 3'b101
    } src_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_IO_WAIT  = 3'd2,
        ST_WB       = 3'd3,
        ST_ERR      = 3'd4
    } seq_state_e;

    // Unused kinds 110/111 fall back to the mux default (B register).
    function automatic src_sel_e remap_kind(input logic [2:0] k);
        return (k[2] & k[1]) ? SRC_B : src_sel_e'(k);
    endfunction

endpackage

// File: rtl/src_sequencer_if.sv
// Decode / data-provider side signals of the operand source sequencer.
interface src_sequencer_if;
    logic       start;
    logic [2:0] src_kind;
    logic       mem_ack;
    logic       io_ack;
    logic       mem_req;
    logic       io_req;
    logic [2:0] src_sel;
    logic       wb_en;
    logic       busy;
    logic       done;
    logic       timeout_err;

    modport master (
        output start, src_kind, mem_ack, io_ack,
        input  mem_req, io_req, src_sel, wb_en, busy, done, timeout_err
    );

    modport slave (
        input  start, src_kind, mem_ack, io_ack,
        output mem_req, io_req, src_sel, wb_en, busy, done, timeout_err
    );
endinterface

// File: rtl/src_sequencer_io_wait_counter.sv
// Counts I/O wait cycles; hit flags the last allowed cycle (never when IO_TIMEOUT=0).
module io_wait_counter
    import src_pkg::*;
#(
    parameter int IO_TIMEOUT = IO_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);
    localparam int CNT_W = (IO_TIMEOUT == 0) ? 1 : $clog2(IO_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((IO_TIMEOUT == 0) ? 0 : IO_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + CNT_W'(1);
    end

    // With the timeout disabled the counter may wrap; it is simply ignored.
    assign hit = (IO_TIMEOUT != 0) && (cnt == LIMIT);
endmodule

// File: rtl/src_sequencer.sv
// Per-instruction operand source controller: mux select, mem/io handshake, write-back strobe.
module src_sequencer
    import src_pkg::*;
#(
    parameter int IO_TIMEOUT = IO_TIMEOUT_DEF
) (
    input logic           clk,
    input logic           rst_n,
    src_sequencer_if.slave bus
);
    seq_state_e state;
    src_sel_e   sel_q, sel_acc;
    logic       mem_req_q, io_req_q, wb_q, busy_q, done_q, terr_q;
    logic       io_hit, cnt_clr, cnt_en;

    assign sel_acc = remap_kind(bus.src_kind);
    assign cnt_clr = (state != ST_IO_WAIT);
    assign cnt_en  = (state == ST_IO_WAIT) && !bus.io_ack;

    io_wait_counter #(.IO_TIMEOUT(IO_TIMEOUT)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .hit   (io_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel_q     <= SRC_B;
            mem_req_q <= 1'b0;
            io_req_q  <= 1'b0;
            wb_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            wb_q   <= 1'b0;
            done_q <= 1'b0;
            terr_q <= 1'b0;
            case (state)
                ST_IDLE: if (bus.start) begin
                    sel_q  <= sel_acc;
                    busy_q <= 1'b1;
                    case (sel_acc)
                        SRC_MEM: begin mem_req_q <= 1'b1; state <= ST_MEM_WAIT; end
                        SRC_IO:  begin io_req_q  <= 1'b1; state <= ST_IO_WAIT;  end
                        default: begin wb_q <= 1'b1; done_q <= 1'b1; state <= ST_WB; end
                    endcase
                end
                ST_MEM_WAIT: if (bus.mem_ack) begin
                    mem_req_q <= 1'b0;
                    wb_q      <= 1'b1;
                    done_q    <= 1'b1;
                    state     <= ST_WB;
                end
                // Ack takes priority over a timeout landing in the same cycle.
                ST_IO_WAIT: if (bus.io_ack) begin
                    io_req_q <= 1'b0;
                    wb_q     <= 1'b1;
                    done_q   <= 1'b1;
                    state    <= ST_WB;
                end else if (io_hit) begin
                    io_req_q <= 1'b0;
                    done_q   <= 1'b1;
                    terr_q   <= 1'b1;
                    state    <= ST_ERR;
                end
                ST_WB, ST_ERR: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.io_req      = io_req_q;
    assign bus.src_sel     = sel_q;
    assign bus.wb_en       = wb_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = terr_q;
endmodule
